// File: rtl/lib_arbiter_pkg.sv
// Shared arbiter-side definitions: address/polarity widths, packed event
// word layout and the default event buffer depth used by the timestamp packer.
package lib_arbiter_pkg;

  localparam int ROW_ADD        = 3;
  localparam int COL_ADD        = 3;
  localparam int POLARITY       = 2;
  localparam int SIZE           = 32;
  localparam int WIDTH          = SIZE + ROW_ADD + COL_ADD + 1;
  localparam int EVT_FIFO_DEPTH = 8;

  localparam logic [POLARITY-1:0] POL_ON  = 2'b10;
  localparam logic [POLARITY-1:0] POL_OFF = 2'b01;

  // Packed event word, MSB to LSB: timestamp, row, column, polarity bit.
  typedef struct packed {
    logic [SIZE-1:0]    ts;
    logic [ROW_ADD-1:0] row;
    logic [COL_ADD-1:0] col;
    logic               pol;
  } evt_word_t;

  // Only the two one-hot codes describe a real pixel polarity.
  function automatic logic pol_is_valid(input logic [POLARITY-1:0] pol);
    return (pol == POL_ON) || (pol == POL_OFF);
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock FIFO for packed event words. Reads are first-word-fall-through:
// rdata_o shows the head word whenever the buffer is non-empty and zero when
// empty. Pointers wrap naturally because DEPTH is a power of two.
module evt_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 39,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level == LW'(DEPTH));
  assign empty_o = (level == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = level;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage: data only, no reset; stale words are masked by empty_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/evt_timestamp_packer.sv
// Event timestamp packer: stamps each arbiter-granted pixel event with a
// free-running cycle counter, packs it as {ts, row, col, pol_bit} and buffers
// it for a ready/valid consumer. Events with an illegal polarity code or
// arriving while the buffer is full are dropped.
// Optional feature: define EVT_DROP_CNT_EN to count dropped events in
// drop_cnt_o (saturating); otherwise drop_cnt_o is tied to zero.
module evt_timestamp_packer
  import lib_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = EVT_FIFO_DEPTH,
  parameter int TS_W       = SIZE,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                evt_valid_i,
  input  logic [ROW_ADD-1:0]  evt_row_i,
  input  logic [COL_ADD-1:0]  evt_col_i,
  input  logic [POLARITY-1:0] evt_pol_i,
  output logic                evt_ready_o,
  output logic                out_valid_o,
  output logic [WIDTH-1:0]    out_data_o,
  input  logic                out_ready_i,
  output logic [LVL_W-1:0]    fifo_level_o,
  output logic [15:0]         drop_cnt_o
);

  logic [TS_W-1:0] ts_cnt;
  evt_word_t       word_p0;
  logic            push_vld_p0;
  logic            pop;
  logic            full;
  logic            empty;

  // Free-running timestamp, zero in the first cycle after reset release.
  always_ff @(posedge clk_i) begin
    if (!reset_i) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  // Stage p0: pack the event with the timestamp of the cycle it is sampled.
  always_comb begin
    word_p0     = '0;
    word_p0.ts  = SIZE'(ts_cnt);
    word_p0.row = evt_row_i;
    word_p0.col = evt_col_i;
    word_p0.pol = (evt_pol_i == POL_ON);
  end

  assign evt_ready_o = !full;
  assign push_vld_p0 = evt_valid_i && !full && pol_is_valid(evt_pol_i);
  assign out_valid_o = !empty;
  assign pop         = out_valid_o && out_ready_i;

  evt_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_vld_p0),
    .wdata_i (word_p0),
    .pop_i   (pop),
    .rdata_o (out_data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

`ifdef EVT_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign drop       = evt_valid_i && (full || !pol_is_valid(evt_pol_i));
  assign drop_cnt_o = drop_cnt;

  // Saturating count of every presented event that was not stored.
  always_ff @(posedge clk_i) begin
    if (!reset_i)  drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc16(drop_cnt);
  end
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_evt_timestamp_packer.sv
// Self-checking bench for evt_timestamp_packer with a scoreboard queue.
module tb_evt_timestamp_packer;
  import lib_arbiter_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                evt_valid_i;
  logic [ROW_ADD-1:0]  evt_row_i;
  logic [COL_ADD-1:0]  evt_col_i;
  logic [POLARITY-1:0] evt_pol_i;
  logic                evt_ready_o;
  logic                out_valid_o;
  logic [WIDTH-1:0]    out_data_o;
  logic                out_ready_i;
  logic [LVL_W-1:0]    fifo_level_o;
  logic [15:0]         drop_cnt_o;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [31:0]      cyc_cnt;
  logic [31:0]      ts_off;
  logic [WIDTH-1:0] sb[$];
  int               exp_drop;

  always #5 clk = ~clk;

  evt_timestamp_packer #(
    .FIFO_DEPTH (DEPTH),
    .TS_W       (SIZE)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .evt_valid_i  (evt_valid_i),
    .evt_row_i    (evt_row_i),
    .evt_col_i    (evt_col_i),
    .evt_pol_i    (evt_pol_i),
    .evt_ready_o  (evt_ready_o),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .fifo_level_o (fifo_level_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  // Reference cycle counter: the expected timestamp is cyc_cnt + ts_off.
  always @(posedge clk) begin
    if (!reset_i) cyc_cnt <= 32'd0;
    else          cyc_cnt <= cyc_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_drop_view();
`ifdef EVT_DROP_CNT_EN
    return (exp_drop > 65535) ? 65535 : exp_drop;
`else
    return 0;
`endif
  endfunction

  // Called at a falling edge with inputs already driven: check outputs,
  // update the scoreboard for this cycle's handshakes, advance one cycle.
  task automatic tick();
    bit               was_full;
    bit               pol_ok;
    logic [WIDTH-1:0] w;
    if (reset_i) begin
      was_full = (sb.size() == DEPTH);
      pol_ok   = (evt_pol_i == 2'b10) || (evt_pol_i == 2'b01);
      chk("level", 64'(fifo_level_o), 64'(sb.size()));
      chk("evt_ready", 64'(evt_ready_o), 64'(!was_full));
      chk("out_valid", 64'(out_valid_o), 64'(sb.size() != 0));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop_view()));
      if (out_ready_i && sb.size() != 0) begin
        chk("out_data", 64'(out_data_o), 64'(sb[0]));
        void'(sb.pop_front());
      end
      if (evt_valid_i) begin
        if (!was_full && pol_ok) begin
          w = {cyc_cnt + ts_off, evt_row_i, evt_col_i, evt_pol_i == 2'b10};
          sb.push_back(w);
        end else begin
          exp_drop++;
        end
      end
    end
    @(posedge clk);
    if (!reset_i) begin
      sb.delete();
      exp_drop = 0;
    end
    @(negedge clk);
  endtask

  task automatic ev(input bit v, input logic [2:0] r, input logic [2:0] c,
                    input logic [1:0] p, input bit ordy);
    evt_valid_i = v;
    evt_row_i   = r;
    evt_col_i   = c;
    evt_pol_i   = p;
    out_ready_i = ordy;
    tick();
  endtask

  task automatic idle(input bit ordy);
    ev(1'b0, 3'd0, 3'd0, 2'b00, ordy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pol;
    reset_i     = 1'b0;
    evt_valid_i = 1'b0;
    evt_row_i   = '0;
    evt_col_i   = '0;
    evt_pol_i   = '0;
    out_ready_i = 1'b0;
    ts_off      = 32'd0;
    exp_drop    = 0;
    @(negedge clk);
    repeat (3) idle(1'b0);

    // Outputs held in reset
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);
    chk("rst_level", 64'(fifo_level_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    chk("rst_ready", 64'(evt_ready_o), 64'd1);

    // Release; cycles 0..9 idle, event in cycle 10
    reset_i = 1'b1;
    repeat (10) idle(1'b0);
    ev(1'b1, 3'd5, 3'd2, 2'b10, 1'b0);
    chk("first_valid", 64'(out_valid_o), 64'd1);
    chk("first_data", 64'(out_data_o), 64'({32'd10, 3'd5, 3'd2, 1'b1}));
    idle(1'b1);

    // Fill to full with downstream stalled, then a ninth event is dropped
    for (int i = 0; i < 8; i++)
      ev(1'b1, 3'(i), 3'(7 - i), (i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
    chk("full_ready", 64'(evt_ready_o), 64'd0);
    chk("full_level", 64'(fifo_level_o), 64'd8);
    ev(1'b1, 3'd1, 3'd1, 2'b10, 1'b0);
    chk("ninth_level", 64'(fifo_level_o), 64'd8);
`ifdef EVT_DROP_CNT_EN
    chk("ninth_drop", 64'(drop_cnt_o), 64'd1);
`else
    chk("ninth_drop", 64'(drop_cnt_o), 64'd0);
`endif

    // Full with push and pop together: pop happens, push is dropped
    ev(1'b1, 3'd2, 3'd2, 2'b01, 1'b1);
    chk("fullpp_level", 64'(fifo_level_o), 64'd7);

    // Drain to 3, then 20 cycles of simultaneous push and pop
    repeat (4) idle(1'b1);
    chk("lvl3", 64'(fifo_level_o), 64'd3);
    for (int i = 0; i < 20; i++) begin
      pol = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      ev(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), pol, 1'b1);
      chk("pp_level", 64'(fifo_level_o), 64'd3);
    end

    // Illegal polarity codes are dropped and never stored
    ev(1'b1, 3'd6, 3'd6, 2'b11, 1'b0);
    chk("pol11_level", 64'(fifo_level_o), 64'd3);
    ev(1'b1, 3'd4, 3'd4, 2'b00, 1'b0);
    chk("pol00_level", 64'(fifo_level_o), 64'd3);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Timestamp wrap: preload all-ones, then events in two consecutive cycles
    force dut.ts_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.ts_cnt;
    ts_off = 32'hFFFF_FFFF - cyc_cnt;
    ev(1'b1, 3'd3, 3'd1, 2'b10, 1'b0);
    ev(1'b1, 3'd1, 3'd3, 2'b01, 1'b0);
    chk("wrap_head_ts", 64'(out_data_o[WIDTH-1 -: 32]), 64'(32'hFFFF_FFFF));
    idle(1'b1);
    chk("wrap_next_ts", 64'(out_data_o[WIDTH-1 -: 32]), 64'd0);
    idle(1'b1);

    // Reset mid-stream with five events buffered
    for (int i = 0; i < 5; i++) ev(1'b1, 3'(i), 3'(i), 2'b10, 1'b0);
    chk("pre_rst_level", 64'(fifo_level_o), 64'd5);
    reset_i = 1'b0;
    ts_off  = 32'd0;
    idle(1'b0);
    chk("mid_rst_level", 64'(fifo_level_o), 64'd0);
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
    reset_i = 1'b1;
    idle(1'b0);
    ev(1'b1, 3'd7, 3'd0, 2'b01, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/evt_timestamp_packer.md
EVT_TIMESTAMP_PACKER -- requirements
Module: evt_timestamp_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning event buffer depth in words; power of 2, at least 2.
REQ-002 SHALL have parameter TS_W, default SIZE (32), meaning timestamp width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port evt_valid_i, input, 1, arbiter-granted event present this cycle.
REQ-006 SHALL have port evt_row_i, input, ROW_ADD, full hierarchical row address of the granted pixel.
REQ-007 SHALL have port evt_col_i, input, COL_ADD, full hierarchical column address of the granted pixel.
REQ-008 SHALL have port evt_pol_i, input, POLARITY, pixel polarity: 2'b10 is ON, 2'b01 is OFF.
REQ-009 SHALL have port evt_ready_o, output, 1, buffer can accept an event.
REQ-010 SHALL have port out_valid_o, output, 1, packed event available.
REQ-011 SHALL have port out_data_o, output, WIDTH, packed event word.
REQ-012 SHALL have port out_ready_i, input, 1, downstream accepts out_data_o.
REQ-013 SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-014 SHALL have port drop_cnt_o, output, 16, dropped-event count.

Function
REQ-015 SHALL keep a free-running TS_W-bit timestamp counter: 0 in the first cycle after reset release, +1 per cycle, wrapping from all-ones to 0.
REQ-016 SHALL pack each accepted event MSB to LSB as {timestamp, row, col, pol_bit}; pol_bit is 1 for ON and 0 for OFF.
REQ-017 SHALL capture the timestamp value of the cycle in which evt_valid_i is sampled high.
REQ-018 SHALL accept an input when evt_valid_i=1, evt_ready_o=1 and evt_pol_i is 2'b10 or 2'b01.
REQ-019 SHALL drive evt_ready_o = (level < FIFO_DEPTH), derived from registered state only; there is no combinational path from out_ready_i.
REQ-020 SHALL drive out_valid_o = (level != 0) and out_data_o = the head word (FIFO order).
REQ-021 SHALL pop the head on out_valid_o && out_ready_i; out_data_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL have latency of 1: an event accepted in cycle N into an empty buffer appears with out_valid_o=1 in cycle N+1.
REQ-023 SHALL, on simultaneous push and pop, leave level unchanged and keep order intact; this applies when not full.
REQ-024 SHALL, when full, still perform a pop in the same cycle but reject the input; that event is dropped.
REQ-025 SHALL drop an event presented with evt_valid_i=1 while full, or with evt_pol_i of 2'b00 or 2'b11.
REQ-026 SHALL wrap the read and write pointers modulo FIFO_DEPTH; level SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-027 SHALL, when reset_i=0 at a clock edge, clear the timestamp, pointers, level, drop count and output register; this also discards events in flight.
REQ-028 SHALL hold these outputs during and after reset: out_valid_o=0, out_data_o=0, fifo_level_o=0, drop_cnt_o=0 and evt_ready_o=1.

Configuration
REQ-029 SHALL, with EVT_DROP_CNT_EN defined, increment drop_cnt_o by 1 per dropped event (REQ-025), saturating at 16'hFFFF.
REQ-030 SHALL, without EVT_DROP_CNT_EN, tie drop_cnt_o to 0 and synthesise no counter; the port SHALL remain present.

Structure
REQ-031 SHALL take ROW_ADD, COL_ADD, POLARITY, SIZE and WIDTH from lib_arbiter_pkg.
REQ-032 SHALL add EVT_FIFO_DEPTH=8 and packed struct typedef evt_word_t {ts, row, col, pol} to lib_arbiter_pkg.
REQ-033 SHALL instantiate one sub-module, evt_sync_fifo (depth, width parameterised; push/pop/full/empty/level); packing, timestamp and drop logic SHALL stay at top level.

Verification
REQ-034 SHALL cover: after reset release, an event (row 3'd5, col 3'd2, ON) in cycle 10 -> out_valid_o in cycle 11 with data {32'd10, 3'd5, 3'd2, 1'b1}.
REQ-035 SHALL cover: 8 events with out_ready_i=0, then a 9th -> evt_ready_o=0 after the 8th, the 9th is dropped, drop_cnt_o=1 (macro on) and level stays 8.
REQ-036 SHALL cover: full, with push and pop in the same cycle -> head popped, input dropped, level 7 next cycle.
REQ-037 SHALL cover: level 3, push and pop every cycle for 20 cycles -> level stays 3 and the output order matches the input order exactly.
REQ-038 SHALL cover: evt_pol_i=2'b11 with valid -> nothing stored and drop_cnt_o increments; with the macro off, drop_cnt_o stays 0.
REQ-039 SHALL cover: the timestamp preloaded near wrap via force to 32'hFFFFFFFF, then events in two consecutive cycles -> timestamps FFFFFFFF then 00000000; reset mid-stream with level 5 -> level 0 and out_valid_o=0 next cycle.
